// File: rtl/llr_loader_pkg.sv
// Shared decoder definitions: default message/input widths and base-matrix
// geometry used by the loader, cnu, vnu and cyc_shift blocks, plus the
// symmetric LLR saturation helper used wherever raw channel LLRs enter the
// decoder datapath.
package llr_loader_pkg;

    localparam int DATA_W = 8;   // decoder message width
    localparam int IN_W   = 12;  // raw channel LLR width
    localparam int R_DEF  = 5;   // block rows of the base matrix
    localparam int D_DEF  = 8;   // lifting size

    // Clip a sign-extended LLR to [-(2^(w-1)-1), +(2^(w-1)-1)]. The most
    // negative code is never produced, so every value has a negatable magnitude.
    function automatic logic signed [31:0] llr_sat(input logic signed [31:0] x,
                                                   input int w);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (x > lim)
            return lim;
        else if (x < -lim)
            return -lim;
        else
            return x;
    endfunction

endpackage

// File: rtl/llr_loader_bank.sv
// One frame bank: depth x data_w register file, single write port and a full
// parallel read of every entry. Contents are not reset; the loader only
// exposes a bank once every entry of it has been written.
//   clk    rising-edge clock
//   we     write enable
//   addr   write index (0..depth-1)
//   wdata  value written at addr
//   rdata  all entries, entry n at rdata[n*data_w +: data_w]
module llr_bank #(
    parameter int data_w = 8,
    parameter int depth  = 40,
    parameter int aw     = $clog2(depth)
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [aw-1:0]             addr,
    input  logic [data_w-1:0]         wdata,
    output logic [depth*data_w-1:0]   rdata
);

    logic [depth-1:0][data_w-1:0] mem;

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    assign rdata = mem;

endmodule

// File: rtl/llr_loader.sv
// Channel-LLR input stage of the LDPC decoder. Saturates a serial LLR stream
// to decoder width and assembles R*D-value codewords into a two-bank
// ping-pong buffer; the completed bank is presented in parallel on l_bus
// while the other bank fills.
//   clk/rst      clock, asynchronous active-low reset
//   in_valid/in_ready/in_llr/in_last   input beat handshake
//   l_bus        presented frame, VNU n reads l_bus[n*data_w +: data_w]
//   frame_valid  l_bus holds a complete frame
//   frame_ack    decoder has latched l_bus, bank may be refilled
//   err_len      one-cycle pulse on a codeword length violation
module llr_loader
    import llr_loader_pkg::*;
#(
    parameter int data_w = DATA_W,
    parameter int in_w   = IN_W,
    parameter int R      = R_DEF,
    parameter int D      = D_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [in_w-1:0]       in_llr,
    input  logic                  in_last,
    output logic [data_w*R*D-1:0] l_bus,
    output logic                  frame_valid,
    input  logic                  frame_ack,
    output logic                  err_len
);

    localparam int N  = R * D;
    localparam int CW = $clog2(N);

    logic [1:0]              full;
    logic [1:0]              full_nxt;
    logic                    wr_bank;
    logic                    rd_bank;
    logic [CW-1:0]           cnt;
    logic                    err_q;
    logic                    accept;
    logic                    release_bank;
    logic                    at_end;
    logic [data_w-1:0]       sat_llr;
    logic [1:0][N*data_w-1:0] bank_q;

    // Gated by rst so the source sees no ready while reset is asserted;
    // otherwise purely a function of registered state.
    assign in_ready     = rst & ~full[wr_bank];
    assign accept       = in_valid & in_ready;
    assign release_bank = frame_ack & full[rd_bank];
    assign at_end       = (cnt == CW'(N - 1));

    assign sat_llr = data_w'(llr_sat({{(32 - in_w){in_llr[in_w-1]}}, in_llr}, data_w));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        llr_bank #(
            .data_w (data_w),
            .depth  (N),
            .aw     (CW)
        ) u_bank (
            .clk   (clk),
            .we    (accept & (wr_bank == 1'(b))),
            .addr  (cnt),
            .wdata (sat_llr),
            .rdata (bank_q[b])
        );
    end

    // A completion can only hit the bank that is not being read when the read
    // bank is full (otherwise in_ready is low), so set and clear never collide.
    always_comb begin
        full_nxt = full;
        if (accept && at_end)
            full_nxt[wr_bank] = 1'b1;
        if (release_bank)
            full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            cnt     <= '0;
            err_q   <= 1'b0;
        end else begin
            full  <= full_nxt;
            err_q <= 1'b0;
            if (accept) begin
                if (at_end) begin
                    // Full-length frame is kept even without in_last.
                    cnt     <= '0;
                    wr_bank <= ~wr_bank;
                    err_q   <= ~in_last;
                end else if (in_last) begin
                    // Short frame: discard and refill the same bank.
                    cnt   <= '0;
                    err_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (release_bank)
                rd_bank <= ~rd_bank;
        end
    end

    // Zero when nothing is presented so stale bank contents never leak out.
    assign frame_valid = full[rd_bank];
    assign l_bus       = frame_valid ? bank_q[rd_bank] : '0;
    assign err_len     = err_q;

endmodule

// File: tb/tb_llr_loader.sv
module tb_llr_loader;

    localparam int DW = 8;
    localparam int IW = 12;
    localparam int N  = 40;
    localparam int LW = DW * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_llr = '0;
    logic          in_last = 1'b0;
    logic [LW-1:0] l_bus;
    logic          frame_valid;
    logic          frame_ack = 1'b0;
    logic          err_len;

    always #5 clk = ~clk;

    llr_loader #(.data_w(DW), .in_w(IW), .R(5), .D(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_llr      (in_llr),
        .in_last     (in_last),
        .l_bus       (l_bus),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .err_len     (err_len)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of completed frames awaiting ack (at most two
    // fit), the frame under assembly, and the expected error pulse.
    logic [LW-1:0] pend[$];
    logic [LW-1:0] part = '0;
    int            part_n = 0;
    bit            err_exp = 1'b0;
    logic [IW-1:0] vals[N];

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] sat_ref(input logic [IW-1:0] raw);
        int v;
        int lim;
        lim = 2 ** (DW - 1) - 1;
        v = int'($signed(raw));
        if (v > lim) v = lim;
        else if (v < -lim) v = -lim;
        return DW'(v);
    endfunction

    task automatic check_out();
        chk("frame_valid", LW'(frame_valid), LW'(pend.size() > 0));
        if (pend.size() > 0) chk("l_bus", l_bus, pend[0]);
        else                 chk("l_bus_idle", l_bus, '0);
        chk("err_len", LW'(err_len), LW'(err_exp));
    endtask

    task automatic step(input bit v, input logic [IW-1:0] llr, input bit last,
                        input bit ack, output bit acc);
        bit exp_rdy;
        bit ackeff;
        in_valid  = v;
        in_llr    = llr;
        in_last   = last;
        frame_ack = ack;
        #1;
        exp_rdy = (pend.size() < 2);
        chk("in_ready", LW'(in_ready), LW'(exp_rdy));
        acc    = v && exp_rdy;
        ackeff = ack && (pend.size() > 0);
        @(posedge clk);
        if (ackeff) void'(pend.pop_front());
        err_exp = 1'b0;
        if (acc) begin
            part[part_n*DW +: DW] = sat_ref(llr);
            part_n++;
            if (part_n == N) begin
                pend.push_back(part);
                err_exp = !last;
                part_n  = 0;
                part    = '0;
            end else if (last) begin
                err_exp = 1'b1;
                part_n  = 0;
                part    = '0;
            end
        end
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        frame_ack = 1'b0;
        check_out();
    endtask

    task automatic send_frame(input int len, input int last_at, input int ack_pct);
        bit acc;
        int tries;
        for (int i = 0; i < len; i++) begin
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 100) begin
                step(1'b1, vals[i], (i == last_at), ($urandom_range(99) < ack_pct), acc);
                tries++;
            end
            chk("beat_accept", LW'(acc), LW'(1));
        end
    endtask

    task automatic rand_vals();
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(3))
                0:       vals[i] = IW'($urandom_range(255));
                1:       vals[i] = IW'(12'hF00 + $urandom_range(255));
                default: vals[i] = IW'($urandom);
            endcase
        end
    endtask

    task automatic model_reset();
        pend.delete();
        part    = '0;
        part_n  = 0;
        err_exp = 1'b0;
    endtask

    initial begin
        bit acc;
        logic [LW-1:0] lb;

        // Reset state
        #2 rst = 1'b0;
        #10;
        chk("rst_in_ready", LW'(in_ready), LW'(0));
        check_out();
        @(posedge clk); #1 rst = 1'b1;

        // 1: ramp frame 0..39
        for (int i = 0; i < N; i++) vals[i] = IW'(i);
        send_frame(N, N - 1, 0);
        chk("t1_valid", LW'(frame_valid), LW'(1));
        lb = l_bus;
        for (int n = 0; n < N; n += 13) chk("t1_slice", LW'(lb[n*DW +: DW]), LW'(n));
        step(1'b0, '0, 1'b0, 1'b1, acc);

        // 2: saturation corners
        rand_vals();
        vals[0] = 12'h7FF; vals[1] = 12'h800; vals[2] = 12'h07F;
        vals[3] = 12'hF81; vals[4] = 12'hFFF;
        send_frame(N, N - 1, 0);
        lb = l_bus;
        chk("sat_p2047", LW'(lb[0*DW +: DW]), LW'(8'h7F));
        chk("sat_m2048", LW'(lb[1*DW +: DW]), LW'(8'h81));
        chk("sat_p127",  LW'(lb[2*DW +: DW]), LW'(8'h7F));
        chk("sat_m127",  LW'(lb[3*DW +: DW]), LW'(8'h81));
        chk("sat_m1",    LW'(lb[4*DW +: DW]), LW'(8'hFF));
        step(1'b0, '0, 1'b0, 1'b1, acc);

        // 3: ping-pong, both banks full, stall, ack, third frame
        rand_vals(); send_frame(N, N - 1, 0);
        rand_vals(); send_frame(N, N - 1, 0);
        rand_vals();
        for (int k = 0; k < 3; k++) step(1'b1, vals[0], 1'b0, 1'b0, acc);
        step(1'b1, vals[0], 1'b0, 1'b1, acc);
        send_frame(N, N - 1, 0);
        step(1'b0, '0, 1'b0, 1'b1, acc);
        step(1'b0, '0, 1'b0, 1'b1, acc);

        // 4: early last, then a good frame into the same bank
        rand_vals(); send_frame(11, 10, 0);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        rand_vals(); send_frame(N, N - 1, 0);
        step(1'b0, '0, 1'b0, 1'b1, acc);

        // 5: missing last, then an ack while nothing is presented
        rand_vals(); send_frame(N, -1, 0);
        step(1'b0, '0, 1'b0, 1'b1, acc);
        step(1'b0, '0, 1'b0, 1'b1, acc);
        step(1'b0, '0, 1'b0, 0, acc);

        // Random traffic with concurrent acks
        for (int f = 0; f < 4; f++) begin
            rand_vals();
            send_frame(N, N - 1, 30);
        end
        for (int k = 0; k < 4 && pend.size() > 0; k++) step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("drained", LW'(frame_valid), LW'(0));

        // 6: reset mid-frame
        rand_vals(); send_frame(20, -1, 0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_ready", LW'(in_ready), LW'(0));
        check_out();
        @(posedge clk); #1 rst = 1'b1;
        rand_vals(); send_frame(N, N - 1, 0);
        step(1'b0, '0, 1'b0, 1'b1, acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
